// File: rtl/flit_assembler.sv
// flit_assembler: joins the head and tail flits of 2-flit NoC packets into a
// single {head_flit, tail_flit} word and holds it until downstream accepts.
// Single-flit (head+tail) packets are emitted as {flit, zeros}. Protocol
// errors (orphan tail/body, VC mismatch, abandoned head) pulse err_out.
// Optional build macro FLIT_ASM_ERR_CNT_EN adds a saturating 16-bit error
// counter (err_cnt) with a synchronous clear (err_cnt_clr).
//
// Handshake (valid/ready): a flit transfers on a cycle where
// flit_in[W-1] == 1 and ready_out == 1; a packet transfers on a cycle where
// pkt_out valid (out_full) and ready_in are both 1. pkt_out is held stable
// while it is valid and ready_in is 0. ready_out never depends on flit_in.
module flit_assembler #(
  parameter int WIDTH_PKT        = 36,
  localparam int WIDTH_FLIT      = WIDTH_PKT / 2,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int ADDRESS_WIDTH    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH_FLIT-1:0] flit_in,
  output logic                  ready_out,
  output logic [WIDTH_PKT-1:0]  pkt_out,
  input  logic                  ready_in,
  output logic                  state_dbg,
  output logic                  err_out
`ifdef FLIT_ASM_ERR_CNT_EN
  ,
  input  logic                  err_cnt_clr,
  output logic [15:0]           err_cnt
`endif
);

  // The address field rides inside the head flit untouched; it only has to fit.
  if ((WIDTH_PKT % 2 != 0) ||
      (3 + VC_ADDRESS_WIDTH + ADDRESS_WIDTH > WIDTH_FLIT)) begin : g_bad_params
    $error("flit_assembler: WIDTH_PKT must be even and wide enough for the flit header");
  end

  typedef enum logic {
    WAIT_HEAD = 1'b0,
    WAIT_TAIL = 1'b1
  } state_t;

  state_t                      state, state_nxt;
  logic [WIDTH_FLIT-1:0]       head_reg, head_nxt;
  logic [VC_ADDRESS_WIDTH-1:0] head_vc, vc_nxt;
  logic                        out_full;
  logic [WIDTH_PKT-1:0]        pkt_reg;

  logic                        flit_fire;
  logic                        is_head;
  logic                        is_tail;
  logic [VC_ADDRESS_WIDTH-1:0] flit_vc;
  logic                        load;
  logic [WIDTH_PKT-1:0]        load_word;
  logic                        err;

  assign ready_out = !out_full || ready_in;
  assign flit_fire = (flit_in[WIDTH_FLIT-1] == 1'b1) && ready_out;
  assign is_head   = flit_in[WIDTH_FLIT-2];
  assign is_tail   = flit_in[WIDTH_FLIT-3];
  assign flit_vc   = flit_in[WIDTH_FLIT-4 -: VC_ADDRESS_WIDTH];

  // pkt_reg is cleared whenever the word leaves, so it reads zero when empty.
  assign pkt_out   = pkt_reg;
  assign state_dbg = (state == WAIT_TAIL);
  // Errors are reported in the cycle of the offending flit, never in reset.
  assign err_out   = err && !rst;

  // Next-state, head capture and packet-load decisions for the accepted flit.
  always_comb begin
    state_nxt = state;
    head_nxt  = head_reg;
    vc_nxt    = head_vc;
    load      = 1'b0;
    load_word = '0;
    err       = 1'b0;
    if (flit_fire) begin
      if (state == WAIT_TAIL && !is_head) begin
        if (is_tail && (flit_vc == head_vc)) begin
          load      = 1'b1;
          load_word = {head_reg, flit_in};
          state_nxt = WAIT_HEAD;
        end else begin
          // Body flit or tail on the wrong VC: drop, keep waiting for the tail.
          err = 1'b1;
        end
      end else begin
        // A head arriving in WAIT_TAIL abandons the pending head, then is
        // treated exactly like a head in WAIT_HEAD.
        if (state == WAIT_TAIL) begin
          err = 1'b1;
        end
        if (!is_head) begin
          err = 1'b1;
        end else if (is_tail) begin
          load      = 1'b1;
          load_word = {flit_in, {WIDTH_FLIT{1'b0}}};
          state_nxt = WAIT_HEAD;
        end else begin
          head_nxt  = flit_in;
          vc_nxt    = flit_vc;
          state_nxt = WAIT_TAIL;
        end
      end
    end
  end

  // State, head capture and output register; a load in the same cycle as a
  // packet transfer replaces the old word so out_full stays set.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= WAIT_HEAD;
      head_reg <= '0;
      head_vc  <= '0;
      out_full <= 1'b0;
      pkt_reg  <= '0;
    end else begin
      state    <= state_nxt;
      head_reg <= head_nxt;
      head_vc  <= vc_nxt;
      if (load) begin
        pkt_reg  <= load_word;
        out_full <= 1'b1;
      end else if (out_full && ready_in) begin
        pkt_reg  <= '0;
        out_full <= 1'b0;
      end
    end
  end

`ifdef FLIT_ASM_ERR_CNT_EN
  // Saturating error counter; a clear coinciding with an error leaves 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (err_cnt_clr) begin
      err_cnt <= err_out ? 16'd1 : 16'd0;
    end else if (err_out && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule
